// File: rtl/seg_readback.sv
// Receive-side decoder for a scanned active-low 7-segment bus: filters each digit
// for stability, inverse-decodes it to a nibble and publishes complete words.
module seg_readback #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            segments,
  input  logic [DIGITS-1:0]     anodes,
  output logic [4*DIGITS-1:0]   value,
  output logic                  valid,
  output logic                  error,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_done
);

  localparam int         IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK     = 7'b1111111;

  typedef enum logic [0:0] {ST_ACQ = 1'b0, ST_PUBLISH = 1'b1} state_t;

  // Returns {hit, nibble}; hit is low for any pattern outside the hex table.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'b1000000: seg_decode = {1'b1, 4'h0};
      7'b1111001: seg_decode = {1'b1, 4'h1};
      7'b0100100: seg_decode = {1'b1, 4'h2};
      7'b0110000: seg_decode = {1'b1, 4'h3};
      7'b0011001: seg_decode = {1'b1, 4'h4};
      7'b0010010: seg_decode = {1'b1, 4'h5};
      7'b0000010: seg_decode = {1'b1, 4'h6};
      7'b1111000: seg_decode = {1'b1, 4'h7};
      7'b0000000: seg_decode = {1'b1, 4'h8};
      7'b0010000: seg_decode = {1'b1, 4'h9};
      7'b0001000: seg_decode = {1'b1, 4'hA};
      7'b0000011: seg_decode = {1'b1, 4'hB};
      7'b0100111: seg_decode = {1'b1, 4'hC};
      7'b0100001: seg_decode = {1'b1, 4'hD};
      7'b0000110: seg_decode = {1'b1, 4'hE};
      7'b0001110: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  logic [DIGITS+6:0]   prev_q;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   err_sh_q, err_sh_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] value_q;
  logic                valid_q, error_q, frame_done_q;
  logic [DIGITS-1:0]   digit_err_q;

  logic [DIGITS+6:0]   sample_s;
  logic                sel_s, same_s, capture_s, cap_upd_s, publish_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic [4:0]          dec_s;

  assign sample_s  = {anodes, segments};
  assign sel_s     = $onehot(~anodes);
  assign same_s    = (sample_s == prev_q);
  assign capture_s = sel_s & same_s & (cnt_q == STABLE_M1);
  assign cap_upd_s = capture_s & (segments != BLANK);
  assign dec_s     = seg_decode(segments);

  // Index of the single active-low anode (meaningful only when sel_s is high).
  always_comb begin
    sel_idx_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sel_idx_s = anodes[i] ? sel_idx_s : IDX_W'(i);
    end
  end

  // Stability counter next state, saturating so a held pattern captures once.
  always_comb begin
    cnt_d = 4'd0;
    if (!sel_s) begin
      cnt_d = 4'd0;
    end else if (!same_s) begin
      cnt_d = 4'd1;
    end else if (cnt_q < STABLE) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Publish FSM next state.
  always_comb begin
    state_d   = state_q;
    publish_s = 1'b0;
    case (state_q)
      ST_ACQ: begin
        if (&seen_q) begin
          state_d   = ST_PUBLISH;
          publish_s = 1'b1;
        end else begin
          state_d = ST_ACQ;
        end
      end
      ST_PUBLISH: state_d = ST_ACQ;
      default:    state_d = ST_ACQ;
    endcase
  end

  // Shadow word update; the publish clear of seen precedes a same-edge capture set.
  always_comb begin
    shadow_d = shadow_q;
    err_sh_d = err_sh_q;
    seen_d   = publish_s ? {DIGITS{1'b0}} : seen_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (cap_upd_s && (sel_idx_s == IDX_W'(k))) begin
        seen_d[k] = 1'b1;
        if (dec_s[4]) begin
          shadow_d[4*k +: 4] = dec_s[3:0];
          err_sh_d[k]        = 1'b0;
        end else begin
          err_sh_d[k] = 1'b1;
        end
      end else begin
        seen_d[k] = seen_d[k];
      end
    end
  end

  // State registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= '0;
      cnt_q        <= 4'd0;
      shadow_q     <= '0;
      err_sh_q     <= '0;
      seen_q       <= '0;
      state_q      <= ST_ACQ;
      value_q      <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      digit_err_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      prev_q       <= sample_s;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      err_sh_q     <= err_sh_d;
      seen_q       <= seen_d;
      state_q      <= state_d;
      frame_done_q <= publish_s;
      if (publish_s) begin
        value_q     <= shadow_q;
        digit_err_q <= err_sh_q;
        error_q     <= |err_sh_q;
        valid_q     <= 1'b1;
      end else begin
        value_q     <= value_q;
        digit_err_q <= digit_err_q;
        error_q     <= error_q;
        valid_q     <= valid_q;
      end
    end
  end

  assign value      = value_q;
  assign valid      = valid_q;
  assign error      = error_q;
  assign digit_err  = digit_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_readback.sv
// Directed bench for seg_readback: scans hand-built digit sequences over the
// multiplexed bus and compares published words against hand-computed values.
module tb_seg_readback;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segments;
  logic [3:0]  anodes;
  logic [15:0] value;
  logic        valid;
  logic        error;
  logic [3:0]  digit_err;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int fd0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [3:0] IDLE  = 4'b1111;

  seg_readback #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .segments   (segments),
    .anodes     (anodes),
    .value      (value),
    .valid      (valid),
    .error      (error),
    .digit_err  (digit_err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Counts frame_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b0100111;  4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;  4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // Hold one bus value for n rising edges; returns 1 time unit after the last edge.
  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
    anodes   = an;
    segments = sg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3, input int n);
    drive(4'b1110, s0, n);
    drive(4'b1101, s1, n);
    drive(4'b1011, s2, n);
    drive(4'b0111, s3, n);
  endtask

  initial begin
    reset    = 1'b1;
    anodes   = IDLE;
    segments = BLANK;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_derr",  32'(digit_err), 32'h0);
    reset = 1'b0;
    drive(IDLE, BLANK, 2);
    check("rst_fd", 32'(fd_cnt), 32'h0);

    // Basic scan 1,2,3,4
    fd0 = fd_cnt;
    scan(seg(4'h1), seg(4'h2), seg(4'h3), seg(4'h4), 6);
    check("t1_fd",    32'(fd_cnt - fd0), 32'd1);
    check("t1_value", 32'(value), 32'h4321);
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_error", 32'(error), 32'h0);
    check("t1_derr",  32'(digit_err), 32'h0);

    // Digit 2 held one cycle short of the stability window
    fd0 = fd_cnt;
    drive(4'b1110, seg(4'h5), 6);
    drive(4'b1101, seg(4'h6), 6);
    drive(4'b1011, seg(4'h7), 3);
    drive(4'b0111, seg(4'h8), 6);
    drive(IDLE, BLANK, 2);
    check("t2_fd_short",    32'(fd_cnt - fd0), 32'd0);
    check("t2_value_short", 32'(value), 32'h4321);
    drive(4'b1011, seg(4'h7), 4);
    drive(IDLE, BLANK, 2);
    check("t2_fd",    32'(fd_cnt - fd0), 32'd1);
    check("t2_value", 32'(value), 32'h8765);

    // Dash on digit 1 keeps its old nibble and flags an error
    fd0 = fd_cnt;
    scan(seg(4'hA), DASH, seg(4'hB), seg(4'hC), 6);
    check("t3_fd",    32'(fd_cnt - fd0), 32'd1);
    check("t3_value", 32'(value), 32'hCB6A);
    check("t3_derr",  32'(digit_err), 32'h2);
    check("t3_error", 32'(error), 32'h1);

    // Two anodes active, or none, never capture
    fd0 = fd_cnt;
    drive(4'b1100, seg(4'h5), 20);
    drive(IDLE, seg(4'h5), 20);
    check("t4_fd_nosel",    32'(fd_cnt - fd0), 32'd0);
    check("t4_value_nosel", 32'(value), 32'hCB6A);
    check("t4_error_nosel", 32'(error), 32'h1);
    // Blank digit is never marked seen
    scan(seg(4'h1), BLANK, seg(4'h2), seg(4'h3), 6);
    drive(IDLE, BLANK, 3);
    check("t4_fd_blank",    32'(fd_cnt - fd0), 32'd0);
    check("t4_value_blank", 32'(value), 32'hCB6A);
    drive(4'b1101, seg(4'h9), 6);
    drive(IDLE, BLANK, 2);
    check("t4_fd",    32'(fd_cnt - fd0), 32'd1);
    check("t4_value", 32'(value), 32'h3291);
    check("t4_error", 32'(error), 32'h0);
    check("t4_derr",  32'(digit_err), 32'h0);

    // Reset mid-frame clears everything immediately
    drive(4'b1110, seg(4'h7), 6);
    drive(4'b1101, seg(4'h7), 6);
    drive(4'b1011, seg(4'h7), 6);
    reset = 1'b1;
    #1;
    check("t5_value", 32'(value), 32'h0);
    check("t5_valid", 32'(valid), 32'h0);
    check("t5_error", 32'(error), 32'h0);
    check("t5_derr",  32'(digit_err), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    fd0 = fd_cnt;
    drive(4'b0111, seg(4'hC), 6);
    drive(IDLE, BLANK, 2);
    check("t5_fd_partial", 32'(fd_cnt - fd0), 32'd0);
    drive(4'b1110, seg(4'hF), 6);
    drive(4'b1101, seg(4'hE), 6);
    drive(4'b1011, seg(4'hD), 6);
    drive(IDLE, BLANK, 2);
    check("t5_fd",     32'(fd_cnt - fd0), 32'd1);
    check("t5_value2", 32'(value), 32'hCDEF);
    check("t5_valid2", 32'(valid), 32'h1);

    // Back-to-back frames with minimum holds and a digit-0 re-capture
    fd0 = fd_cnt;
    scan(seg(4'h1), seg(4'h2), seg(4'h3), seg(4'h4), 4);
    drive(4'b1110, seg(4'h5), 4);
    check("t6_fd1",    32'(fd_cnt - fd0), 32'd1);
    check("t6_value1", 32'(value), 32'h4321);
    drive(4'b1101, seg(4'h6), 4);
    drive(4'b1110, seg(4'h9), 4);
    drive(4'b1011, seg(4'h7), 4);
    drive(4'b0111, seg(4'h8), 4);
    drive(IDLE, BLANK, 2);
    check("t6_fd2",    32'(fd_cnt - fd0), 32'd2);
    check("t6_value2", 32'(value), 32'h8769);
    check("t6_error2", 32'(error), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
